// File: rtl/bcd_disp_pkg.sv
// Shared constants for the three-digit BCD scan display: segment patterns,
// digit-select enum and one-hot anode codes.
package bcd_disp_pkg;

   // Active-high {a,b,c,d,e,f,g}
   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      UNITS    = 2'd0,
      TENS     = 2'd1,
      HUNDREDS = 2'd2
   } digit_e;

   localparam logic [2:0] AN_UNITS    = 3'b001;
   localparam logic [2:0] AN_TENS     = 3'b010;
   localparam logic [2:0] AN_HUNDREDS = 3'b100;
   localparam logic [2:0] AN_OFF      = 3'b000;

   function automatic logic [2:0] anode_of(input digit_e d);
      case (d)
         UNITS:    anode_of = AN_UNITS;
         TENS:     anode_of = AN_TENS;
         HUNDREDS: anode_of = AN_HUNDREDS;
         default:  anode_of = AN_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg.sv
// Combinational nibble to seven-segment decoder; nibbles above 9 show a dash.
module bcd_to_seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nib)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed seven-segment driver for the BCD adder result.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_display_scan
   import bcd_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 1000
) (
   input  logic       Clock,
   input  logic       Reset_N,
   input  logic       Load,
   input  logic       Cout,
   input  logic [3:0] Sum1,
   input  logic [3:0] Sum0,
   output logic [6:0] Seg,
   output logic [2:0] Anode,
   output logic       Err
);

   localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic             hold_c;
   logic [3:0]       hold_1;
   logic [3:0]       hold_0;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wrap;
   digit_e           state;
   digit_e           state_nxt;
   logic [3:0]       nib;
   logic [6:0]       seg_dec;
   logic [6:0]       seg_nxt;
   logic [2:0]       anode_nxt;
   logic             blank;

   // Capture register and error flag; Load never touches the scan state
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         hold_c <= 1'b0;
         hold_1 <= 4'd0;
         hold_0 <= 4'd0;
         Err    <= 1'b0;
      end else if (Load) begin
         hold_c <= Cout;
         hold_1 <= Sum1;
         hold_0 <= Sum0;
         Err    <= (Sum1 > 4'd9) || (Sum0 > 4'd9);
      end
   end

   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         cnt   <= '0;
         state <= UNITS;
      end else begin
         cnt   <= cnt_nxt;
         state <= state_nxt;
      end
   end

   always_comb begin
      wrap      = (cnt == CNT_MAX);
      cnt_nxt   = wrap ? '0 : cnt + CNT_W'(1);
      state_nxt = state;
      if (wrap) begin
         case (state)
            UNITS:    state_nxt = TENS;
            TENS:     state_nxt = HUNDREDS;
            HUNDREDS: state_nxt = UNITS;
            default:  state_nxt = UNITS;
         endcase
      end
   end

   always_comb begin
      nib = hold_0;
      case (state)
         UNITS:    nib = hold_0;
         TENS:     nib = hold_1;
         HUNDREDS: nib = {3'b000, hold_c};
         default:  nib = hold_0;
      endcase
   end

   bcd_to_seg u_dec (
      .nib (nib),
      .seg (seg_dec)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Only a true zero nibble is suppressed; a dash is never mistaken for zero
   assign blank = ((state == HUNDREDS) && !hold_c) ||
                  ((state == TENS) && !hold_c && (hold_1 == 4'd0));
`else
   assign blank = 1'b0;
`endif

   // Last count of each slot is the dead-time gap between digits
   always_comb begin
      anode_nxt = anode_of(state);
      seg_nxt   = blank ? SEG_BLANK : seg_dec;
      if (wrap) begin
         anode_nxt = AN_OFF;
         seg_nxt   = SEG_BLANK;
      end
   end

   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         Seg   <= SEG_BLANK;
         Anode <= AN_OFF;
      end else begin
         Seg   <= seg_nxt;
         Anode <= anode_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan against a cycle-count reference model.
module tb_bcd_display_scan;

   localparam int RD = 4;

   logic       Clock;
   logic       Reset_N;
   logic       Load;
   logic       Cout;
   logic [3:0] Sum1;
   logic [3:0] Sum0;
   logic [6:0] Seg;
   logic [2:0] Anode;
   logic       Err;

   int checks;
   int failures;

   // Reference model: edges since reset release plus the captured value
   int         tick;
   logic       mc;
   logic [3:0] m1;
   logic [3:0] m0;
   logic       merr;
   logic [6:0] exp_seg;
   logic [2:0] exp_an;

   bcd_display_scan #(.REFRESH_DIV(RD)) dut (
      .Clock   (Clock),
      .Reset_N (Reset_N),
      .Load    (Load),
      .Cout    (Cout),
      .Sum1    (Sum1),
      .Sum0    (Sum0),
      .Seg     (Seg),
      .Anode   (Anode),
      .Err     (Err)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   task automatic check3(input string tag, input logic [2:0] an, input logic [6:0] sg,
                         input logic er);
      checks++;
      assert (Anode === an) else begin
         failures++;
         $error("FAIL %s anode t=%0d got=%b exp=%b", tag, tick, Anode, an);
      end
      checks++;
      assert (Seg === sg) else begin
         failures++;
         $error("FAIL %s seg t=%0d got=%b exp=%b", tag, tick, Seg, sg);
      end
      checks++;
      assert (Err === er) else begin
         failures++;
         $error("FAIL %s err t=%0d got=%b exp=%b", tag, tick, Err, er);
      end
   endtask

   task automatic step(input string tag, input logic ld, input logic c,
                       input logic [3:0] s1, input logic [3:0] s0);
      int pos;
      int slot;
      int digit;
      logic zero_blank;
      Load = ld;
      Cout = c;
      Sum1 = s1;
      Sum0 = s0;
      @(posedge Clock);
      pos  = tick % RD;
      slot = (tick / RD) % 3;
      if (pos == RD - 1) begin
         exp_an  = 3'b000;
         exp_seg = 7'b0000000;
      end else begin
         exp_an = 3'b001 << slot;
         digit  = (slot == 0) ? int'(m0) : (slot == 1) ? int'(m1) : int'(mc);
         zero_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         if (slot == 2 && mc == 1'b0) zero_blank = 1'b1;
         if (slot == 1 && mc == 1'b0 && m1 == 4'd0) zero_blank = 1'b1;
`endif
         exp_seg = zero_blank ? 7'b0000000 : seg_of(digit);
      end
      if (ld) begin
         mc   = c;
         m1   = s1;
         m0   = s0;
         merr = (s1 > 4'd9) || (s0 > 4'd9);
      end
      tick++;
      #1;
      check3(tag, exp_an, exp_seg, merr);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 4'd0, 4'd0);
   endtask

   task automatic model_reset();
      tick = 0;
      mc   = 1'b0;
      m1   = 4'd0;
      m0   = 4'd0;
      merr = 1'b0;
   endtask

   initial begin
      int waited;
      checks   = 0;
      failures = 0;
      Load = 1'b0; Cout = 1'b0; Sum1 = 4'd0; Sum0 = 4'd0;
      model_reset();

      // Reset state
      Reset_N = 1'b0;
      #1;
      check3("reset_async", 3'b000, 7'b0000000, 1'b0);
      repeat (2) @(posedge Clock);
      #1;
      check3("reset_hold", 3'b000, 7'b0000000, 1'b0);
      @(negedge Clock);
      Reset_N = 1'b1;

      // Idle scan of 000 for two frames
      idle("idle", 6 * RD);

      // 198
      step("ld198", 1'b1, 1'b1, 4'd9, 4'd8);
      idle("show198", 3 * RD);

      // Dash on units with Err, then a clean load clears Err
      step("ld_dash", 1'b1, 1'b0, 4'd3, 4'd12);
      idle("show_dash", 3 * RD);
      step("ld045", 1'b1, 1'b0, 4'd4, 4'd5);
      idle("show045", 3 * RD);

      // Leading zeros, then a zero in units only
      step("ld007", 1'b1, 1'b0, 4'd0, 4'd7);
      idle("show007", 3 * RD);
      step("ld030", 1'b1, 1'b0, 4'd3, 4'd0);
      idle("show030", 3 * RD);
      step("ld_tdash", 1'b1, 1'b0, 4'd14, 4'd0);
      idle("show_tdash", 3 * RD);

      // Load pulse on a dead-time cycle
      while (tick % RD != RD - 1) step("to_dead", 1'b0, 1'b0, 4'd0, 4'd0);
      step("ld_dead", 1'b1, 1'b1, 4'd6, 4'd2);
      idle("show_dead", 3 * RD);

      // Load held high across several edges
      for (int i = 0; i < 2 * RD; i++)
         step("ld_held", 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
              4'($urandom_range(0, 9)));

      // Randomized loads, including out-of-range nibbles
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0)
            step("rand_ld", 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
         else
            step("rand_idle", 1'b0, 1'($urandom), 4'($urandom), 4'($urandom));
      end

      // Asynchronous reset while the tens digit is lit
      waited = 0;
      while (Anode !== 3'b010 && waited < 6 * RD) begin
         step("to_tens", 1'b0, 1'b0, 4'd0, 4'd0);
         waited++;
      end
      checks++;
      assert (waited < 6 * RD) else begin
         failures++;
         $error("FAIL wait_tens got=%b exp=%b", Anode, 3'b010);
      end
      #2;
      Reset_N = 1'b0;
      #1;
      check3("reset_mid", 3'b000, 7'b0000000, 1'b0);
      model_reset();
      @(posedge Clock);
      #1;
      check3("reset_mid_hold", 3'b000, 7'b0000000, 1'b0);
      @(negedge Clock);
      Reset_N = 1'b1;
      idle("after_reset", 3 * RD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
